// File: rtl/fc_ctrl.sv
// Layer sequencer for the fully-connected datapath. It walks output blocks by
// input blocks and, for each pair, handshakes the loader, starts the AGU and waits for it.
module fc_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    output logic             busy,
    input  logic [1:0]       conf_mode,
    input  logic [CNT_W-1:0] conf_in_blk,
    input  logic [CNT_W-1:0] conf_out_blk,
    input  logic [CNT_W-1:0] conf_idx_cnt,
    input  logic [CNT_W-1:0] conf_trip_cnt,
    output logic             buf_req,
    input  logic             buf_ready,
    output logic             buf_release,
    output logic             agu_start,
    input  logic             agu_done,
    output logic [1:0]       agu_mode,
    output logic [CNT_W-1:0] agu_idx_cnt,
    output logic [CNT_W-1:0] agu_trip_cnt,
    output logic             agu_is_new,
    output logic             wb_req,
    input  logic             wb_ack,
    output logic [CNT_W-1:0] in_idx,
    output logic [CNT_W-1:0] out_idx
);

    // state    | meaning
    // IDLE     | waiting for start; config latched on acceptance
    // WAIT_BUF | buf_req high until the loader grants buffers
    // ISSUE    | one-cycle agu_start for the current (in_idx, out_idx)
    // RUN      | waiting for agu_done
    // WB       | wb_req high until the writeback engine acks
    // FIN      | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_ISSUE,
        S_RUN,
        S_WB,
        S_FIN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] in_blk_q, out_blk_q;
    logic [CNT_W-1:0] in_idx_nxt, out_idx_nxt;
    logic             latch_conf;
    logic             release_nxt;
    logic             last_in, last_out;

    // Latched counts are non-zero whenever these are evaluated, so the -1 never wraps.
    assign last_in  = (in_idx  == in_blk_q  - CNT_W'(1));
    assign last_out = (out_idx == out_blk_q - CNT_W'(1));

    always_comb begin
        state_nxt   = state;
        in_idx_nxt  = in_idx;
        out_idx_nxt = out_idx;
        latch_conf  = 1'b0;
        release_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_conf  = 1'b1;
                    in_idx_nxt  = '0;
                    out_idx_nxt = '0;
                    if (conf_in_blk == '0 || conf_out_blk == '0)
                        state_nxt = S_FIN;
                    else
                        state_nxt = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (buf_ready)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (agu_done) begin
                    release_nxt = 1'b1;
                    if (last_in) begin
                        state_nxt = S_WB;
                    end else begin
                        in_idx_nxt = in_idx + CNT_W'(1);
                        state_nxt  = S_WAIT_BUF;
                    end
                end
            end
            S_WB: begin
                if (wb_ack) begin
                    if (last_out) begin
                        state_nxt = S_FIN;
                    end else begin
                        out_idx_nxt = out_idx + CNT_W'(1);
                        in_idx_nxt  = '0;
                        state_nxt   = S_WAIT_BUF;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            in_idx       <= '0;
            out_idx      <= '0;
            in_blk_q     <= '0;
            out_blk_q    <= '0;
            agu_mode     <= '0;
            agu_idx_cnt  <= '0;
            agu_trip_cnt <= '0;
            buf_release  <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_idx      <= in_idx_nxt;
            out_idx     <= out_idx_nxt;
            buf_release <= release_nxt;
            if (latch_conf) begin
                in_blk_q     <= conf_in_blk;
                out_blk_q    <= conf_out_blk;
                agu_mode     <= conf_mode;
                agu_idx_cnt  <= conf_idx_cnt;
                agu_trip_cnt <= conf_trip_cnt;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign buf_req    = (state == S_WAIT_BUF);
    assign agu_start  = (state == S_ISSUE);
    assign agu_is_new = agu_start && (in_idx == '0);
    assign wb_req     = (state == S_WB);
    assign done       = (state == S_FIN);

endmodule
